// File: rtl/irq_arbiter.sv
// irq_arbiter: latches N interrupt sources as pending and offers the
// highest-priority enabled pending vector to a single interrupt sink.
// An offer retires only when the sink acknowledges that exact vector;
// a mismatched acknowledge produces a one-cycle ack_err pulse.
// Optional feature macro: CARBON_IRQ_ARB_EDGE_EN selects rising-edge
// event detection; when undefined, sources are level-sensitive.
module irq_arbiter #(
    parameter int N      = 32,
    parameter int PRIO_W = 0,
    parameter int VEC_W  = (N <= 1) ? 1 : $clog2(N),
    parameter int PW     = (PRIO_W < 1) ? 1 : PRIO_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      irq_src,
    input  logic [N-1:0]      irq_enable,
    input  logic [N*PW-1:0]   prio_cfg,
    output logic              irq_valid,
    output logic [VEC_W-1:0]  irq_vector,
    output logic [PW-1:0]     irq_prio,
    input  logic              irq_ack,
    input  logic [VEC_W-1:0]  irq_ack_vector,
    output logic [N-1:0]      pending,
    output logic              ack_err
);

    typedef enum logic {IDLE, OFFER} state_t;

    // With no priority field every source is treated as priority 0.
    localparam bit PRIO_ON = (PRIO_W != 0);

    state_t             state_reg;
    logic               irq_valid_reg;
    logic [VEC_W-1:0]   irq_vector_reg;
    logic [PW-1:0]      irq_prio_reg;
    logic [N-1:0]       pending_reg;
    logic [N-1:0]       pending_next;
    logic               ack_err_reg;

    logic [N-1:0]       src_event;
    logic [N-1:0]       clr_mask;
    logic [PW-1:0]      prio_arr [N];
    logic               ack_hit;
    logic               ack_bad;
    logic               win_found;
    logic [VEC_W-1:0]   win_idx;
    logic [PW-1:0]      win_prio;

    // Per-source priority slices, forced to zero when priorities are disabled.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_prio
            assign prio_arr[gi] = PRIO_ON ? prio_cfg[gi*PW +: PW] : '0;
        end
    endgenerate

`ifdef CARBON_IRQ_ARB_EDGE_EN
    logic [N-1:0] src_prev_reg;

    // Previous source values; reset to 0 so a line high out of reset counts once.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_prev_reg <= '0;
        end else begin
            src_prev_reg <= irq_src;
        end
    end

    assign src_event = irq_src & ~src_prev_reg;
`else
    assign src_event = irq_src;
`endif

    assign ack_hit = (state_reg == OFFER) && irq_ack && (irq_ack_vector == irq_vector_reg);
    assign ack_bad = (state_reg == OFFER) && irq_ack && (irq_ack_vector != irq_vector_reg);

    // Pending update: an accepted ack clears its bit, but a new event in the same cycle wins.
    always_comb begin
        clr_mask = '0;
        if (ack_hit) begin
            clr_mask[irq_vector_reg] = 1'b1;
        end
        pending_next = (pending_reg & ~clr_mask) | src_event;
    end

    // Winner: strictly greater priority replaces the current best, so ties keep the lowest index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_prio  = '0;
        for (int i = 0; i < N; i++) begin
            if (pending_reg[i] && irq_enable[i] && (!win_found || (prio_arr[i] > win_prio))) begin
                win_found = 1'b1;
                win_idx   = i[VEC_W-1:0];
                win_prio  = prio_arr[i];
            end
        end
    end

    // Offer FSM with registered outputs; the offer is held until the exact vector is acked.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            irq_valid_reg  <= 1'b0;
            irq_vector_reg <= '0;
            irq_prio_reg   <= '0;
            pending_reg    <= '0;
            ack_err_reg    <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            ack_err_reg <= ack_bad;
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        irq_vector_reg <= win_idx;
                        irq_prio_reg   <= win_prio;
                        irq_valid_reg  <= 1'b1;
                        state_reg      <= OFFER;
                    end
                end
                OFFER: begin
                    if (ack_hit) begin
                        irq_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    irq_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign irq_valid  = irq_valid_reg;
    assign irq_vector = irq_vector_reg;
    assign irq_prio   = irq_prio_reg;
    assign pending    = pending_reg;
    assign ack_err    = ack_err_reg;

endmodule

// File: tb/tb_irq_arbiter.sv
// Testbench for irq_arbiter (N=8, PRIO_W=2): directed scenarios plus random
// traffic, all compared every cycle against a behavioural model.
module tb_irq_arbiter;

    localparam int N      = 8;
    localparam int PRIO_W = 2;
    localparam int PW     = 2;
    localparam int VEC_W  = 3;
`ifdef CARBON_IRQ_ARB_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      irq_src;
    logic [N-1:0]      irq_enable;
    logic [N*PW-1:0]   prio_cfg;
    logic              irq_valid;
    logic [VEC_W-1:0]  irq_vector;
    logic [PW-1:0]     irq_prio;
    logic              irq_ack;
    logic [VEC_W-1:0]  irq_ack_vector;
    logic [N-1:0]      pending;
    logic              ack_err;

    int checks = 0;
    int errors = 0;

    // Model state
    bit m_pend [N];
    bit m_prev [N];
    bit m_busy;
    int m_vec;
    int m_prio;
    bit m_err;
    bit auto_ack;
    int offers_q [$];
    int cycle = 0;

    irq_arbiter #(.N(N), .PRIO_W(PRIO_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_src        (irq_src),
        .irq_enable     (irq_enable),
        .prio_cfg       (prio_cfg),
        .irq_valid      (irq_valid),
        .irq_vector     (irq_vector),
        .irq_prio       (irq_prio),
        .irq_ack        (irq_ack),
        .irq_ack_vector (irq_ack_vector),
        .pending        (pending),
        .ack_err        (ack_err)
    );

    always #5 clk = ~clk;

    function automatic int prio_of(int i);
        logic [N*PW-1:0] t;
        t = prio_cfg >> (i * PW);
        return int'(t[PW-1:0]);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Advance one clock: predict from the current inputs, then compare after the edge.
    task automatic step();
        bit np [N];
        bit acc, bad, n_busy, n_err, found;
        int n_vec, n_prio;
        logic [N-1:0] exp_p;
        if (auto_ack) begin
            irq_ack        = m_busy;
            irq_ack_vector = m_vec[VEC_W-1:0];
        end
        acc = m_busy && irq_ack && (int'(irq_ack_vector) == m_vec);
        bad = m_busy && irq_ack && !acc;
        n_busy = m_busy; n_vec = m_vec; n_prio = m_prio;
        for (int i = 0; i < N; i++) begin
            bit ev;
            ev = EDGE ? (irq_src[i] && !m_prev[i]) : irq_src[i];
            np[i] = ev || (m_pend[i] && !(acc && m_vec == i));
        end
        if (m_busy) begin
            if (acc) n_busy = 0;
        end else begin
            found = 0;
            for (int p = (1 << PW) - 1; p >= 0 && !found; p--) begin
                for (int i = 0; i < N && !found; i++) begin
                    if (m_pend[i] && irq_enable[i] && prio_of(i) == p) begin
                        found = 1; n_busy = 1; n_vec = i; n_prio = p;
                    end
                end
            end
        end
        n_err = bad;
        if (rst) begin
            n_busy = 0; n_vec = 0; n_prio = 0; n_err = 0;
            for (int i = 0; i < N; i++) np[i] = 0;
        end
        @(posedge clk);
        #1;
        cycle++;
        if (!rst && acc)
            $display("cycle %0d: vector %0d acknowledged (prio %0d)", cycle, m_vec, m_prio);
        if (n_busy && !m_busy) offers_q.push_back(n_vec);
        for (int i = 0; i < N; i++) begin
            m_prev[i] = rst ? 1'b0 : irq_src[i];
            m_pend[i] = np[i];
            exp_p[i]  = np[i];
        end
        m_busy = n_busy; m_vec = n_vec; m_prio = n_prio; m_err = n_err;
        chk("irq_valid", int'(irq_valid), int'(m_busy));
        chk("pending", int'(pending), int'(exp_p));
        chk("ack_err", int'(ack_err), int'(m_err));
        if (m_busy) begin
            chk("irq_vector", int'(irq_vector), m_vec);
            chk("irq_prio", int'(irq_prio), m_prio);
        end
    endtask

    task automatic steps(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int n_off;
        rst = 1'b1; irq_src = '0; irq_enable = '1; prio_cfg = '0;
        irq_ack = 1'b0; irq_ack_vector = '0; auto_ack = 1'b0;
        m_busy = 0; m_vec = 0; m_prio = 0; m_err = 0;
        for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_prev[i] = 0; end

        // Reset state
        steps(2);
        chk("rst_valid", int'(irq_valid), 0);
        chk("rst_vector", int'(irq_vector), 0);
        chk("rst_prio", int'(irq_prio), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_ack_err", int'(ack_err), 0);
        rst = 1'b0;
        step();

        // Single pulse on source 2, prio 1, combinational sink
        prio_cfg = 16'h0010; auto_ack = 1'b1;
        irq_src = 8'h04; step();
        irq_src = 8'h00; step();
        chk("tp1_valid", int'(irq_valid), 1);
        chk("tp1_vector", int'(irq_vector), 2);
        chk("tp1_prio", int'(irq_prio), 1);
        step();
        chk("tp1_valid_off", int'(irq_valid), 0);
        chk("tp1_pending", int'(pending), 0);

        // Priority order with tie on the lower index
        prio_cfg = 16'h0331; offers_q.delete();
        irq_src = 8'h15; step();
        irq_src = 8'h00; steps(8);
        chk("tp2_count", offers_q.size(), 3);
        if (offers_q.size() == 3) begin
            chk("tp2_first", offers_q[0], 2);
            chk("tp2_second", offers_q[1], 4);
            chk("tp2_third", offers_q[2], 0);
        end

        // Mismatched acknowledge
        prio_cfg = '0; auto_ack = 1'b0;
        irq_src = 8'h20; step();
        irq_src = 8'h00; step();
        chk("tp3_vector", int'(irq_vector), 5);
        irq_ack = 1'b1; irq_ack_vector = 3'd3; step();
        chk("tp3_err", int'(ack_err), 1);
        chk("tp3_held", int'(irq_valid), 1);
        chk("tp3_pending", int'(pending), 32);
        irq_ack = 1'b0; step();
        chk("tp3_err_off", int'(ack_err), 0);
        irq_ack = 1'b1; irq_ack_vector = 3'd5; step();
        chk("tp3_retired", int'(irq_valid), 0);
        chk("tp3_clear", int'(pending), 0);
        irq_ack = 1'b0;

        // Masked source latches but is not offered until enabled
        irq_enable = 8'hBF;
        irq_src = 8'h40; step();
        irq_src = 8'h00; steps(2);
        chk("tp4_pending", int'(pending), 64);
        chk("tp4_no_offer", int'(irq_valid), 0);
        irq_enable = 8'hFF; step();
        chk("tp4_offer", int'(irq_valid), 1);
        chk("tp4_vector", int'(irq_vector), 6);
        auto_ack = 1'b1; step();
        auto_ack = 1'b0;

        // Reset during an offer
        prio_cfg = 16'hC000;
        irq_src = 8'hA0; step();
        irq_src = 8'h00; step();
        chk("tp5_vector", int'(irq_vector), 7);
        chk("tp5_pending", int'(pending), 160);
        rst = 1'b1; step();
        chk("tp5_valid", int'(irq_valid), 0);
        chk("tp5_pending_rst", int'(pending), 0);
        chk("tp5_vector_rst", int'(irq_vector), 0);
        rst = 1'b0;

        // Source held high for 20 cycles
        prio_cfg = '0; auto_ack = 1'b1; offers_q.delete();
        irq_src = 8'h02; steps(20);
        irq_src = 8'h00; steps(6);
        n_off = offers_q.size();
        chk("tp6_offers", n_off, EDGE ? 1 : 10);
        auto_ack = 1'b0;

        // Random traffic
        for (int k = 0; k < 800; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < N; i++) irq_src[i] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) irq_enable = N'($urandom);
            if ($urandom_range(0, 31) == 0) prio_cfg = (N*PW)'($urandom);
            irq_ack = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) irq_ack_vector = VEC_W'($urandom);
            else irq_ack_vector = m_vec[VEC_W-1:0];
            step();
        end
        rst = 1'b0; irq_ack = 1'b0; irq_src = '0;
        steps(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Interrupt controller that collects N raw interrupt source lines, latches them as pending, and offers the highest-priority enabled pending vector to the CPU-side interrupt sink. It drives the source side of the `irq_if` contract (`irq_valid`, `irq_vector`, priority) and retires a request only when the sink acknowledges that exact vector. It sits between peripheral interrupt outputs and the core's interrupt entry logic.

## Interface
- `N`, 32, number of interrupt sources; VEC_W = (N<=1) ? 1 : $clog2(N).
- `PRIO_W`, 0, priority width per source. If 0, every priority is 0 and the `irq_prio` port is 1 bit, tied to 0. PW = max(1, PRIO_W).
- `clk`  in  1  clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `irq_src`  in  N  raw source lines, sampled on `clk`.
- `irq_enable`  in  N  per-source enable mask; quasi-static.
- `prio_cfg`  in  N*PW  priority of source i at bits [i*PW +: PW]; larger value means higher priority; quasi-static.
- `irq_valid`  out  1  offer to the sink is active.
- `irq_vector`  out  VEC_W  vector being offered.
- `irq_prio`  out  PW  priority of the offered vector.
- `irq_ack`  in  1  sink accepts the current offer.
- `irq_ack_vector`  in  VEC_W  vector the sink claims to accept.
- `pending`  out  N  current pending register.
- `ack_err`  out  1  one-cycle pulse on a mismatched acknowledge.

## Operation
- **Pending set.** `pending[i]` sets when source i has an event: `irq_src[i]`=1 in level mode (see Configuration).
- **Pending clear.** `pending[i]` clears only on a valid acknowledge of vector i.
- **Set/clear conflict.** A set and a clear of the same bit in the same cycle resolve to set. New events are never lost.
- **Masking.** Disabled sources still latch pending; they are only excluded from selection.
- **Winner selection.** The winner is the maximum `prio_cfg` among `pending & irq_enable`. Ties go to the lowest index.
- **FSM states: IDLE, OFFER.**
  - IDLE: if any `pending & irq_enable` bit is set, register the winner into `irq_vector`/`irq_prio` and go to OFFER. Otherwise stay.
  - OFFER: `irq_valid`=1; `irq_vector` and `irq_prio` are held stable.
    - `irq_ack`=1 with `irq_ack_vector`==`irq_vector`: clear that pending bit, go to IDLE.
    - `irq_ack`=1 with any other `irq_ack_vector`: pulse `ack_err`, stay in OFFER, pending unchanged.
- **No preemption.** A higher-priority arrival during OFFER waits for the next IDLE.
- **No retraction.** Clearing `irq_enable` for the offered vector during OFFER does not withdraw the offer.
- `irq_ack` while in IDLE is ignored and raises no error.

## Timing
- Reset values: `irq_valid`=0, `irq_vector`=0, `irq_prio`=0, `pending`=0, `ack_err`=0, FSM=IDLE. Reset asserted mid-OFFER drops the offer at the next edge.
- Latency: a source event sampled at edge t sets `pending` after t. The arbiter selects at edge t+1, so `irq_valid`=1 after edge t+1 (2 cycles).
- Acknowledge is accepted in the same cycle `irq_valid`=1; a combinational sink ack gives 1-cycle offers.
- After every accepted ack, `irq_valid`=0 for at least one cycle (the IDLE cycle). Peak throughput is one interrupt per 2 cycles.
- `ack_err` is registered: it is high in the cycle after the bad ack.
- Level mode: a source held high through its ack re-pends immediately (set wins) and re-offers 2 cycles after the ack.

## Configuration
- `CARBON_IRQ_ARB_EDGE_EN` defined: each source has a registered previous-value bit. An event is a 0→1 transition of `irq_src[i]`, so a line held high produces exactly one interrupt. The previous-value bits reset to 0, so a line high out of reset counts as one event.
- Undefined: level mode. An event is `irq_src[i]`=1 in any cycle, and no edge registers are instantiated.

## Test plan
- N=8, PRIO_W=2, level mode. `irq_src[2]` high for 1 cycle, `prio_cfg` for source 2 = 1, stub sink with combinational ack → `irq_valid` 2 cycles later with vector 2, prio 1. `pending[2]` clears and `irq_valid`=0 on the next cycle.
- Sources 0, 2, 4 pulsed together with priorities 1, 3, 3 → offers in order 4? No: order is 2, 4, 0 (tie 3/3 resolves to the lower index, 2), each offer separated by one idle cycle.
- Offer of vector 5 acked with `irq_ack_vector`=3 → `ack_err` pulses once, offer of 5 is held, `pending[5]` stays 1. A correct ack of 5 then retires it.
- `irq_enable[6]`=0 while `irq_src[6]` is pulsed → `pending[6]`=1, no offer. Set `irq_enable[6]`=1 → vector 6 offered 1 cycle later.
- Reset asserted during an offer of vector 7 with `pending`=8'hA0 → next cycle `irq_valid`=0, `pending`=0, `irq_vector`=0.
- With `CARBON_IRQ_ARB_EDGE_EN`: `irq_src[1]` held high for 20 cycles → exactly one offer of vector 1. Without it: repeated offers every 2 cycles.
